// File: rtl/uart_rx_ctrl.sv
// UART receive controller: line sync, start-bit validation, bit timing, shift strobes and output buffer.
// First strobe 15 cycles after the start edge; data_ready rises 2 cycles after the last strobe; no backpressure (unread data is overwritten and flagged).
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     serial_in,
  input  logic [NUM_DATA_BITS:0]   packet_data,
  input  logic                     data_read,
  output logic                     serial_sync,
  output logic                     shift_strobe,
  output logic [NUM_DATA_BITS-1:0] rx_data,
  output logic                     data_ready,
  output logic                     framing_error,
  output logic                     overrun_error,
  output logic                     busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_DATA_BITS + 2);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_IDX  = BW'(NUM_DATA_BITS);

  typedef enum logic [1:0] {IDLE, START, RECV, STOP_CHK} state_t;

  state_t        state, next_state;
  logic          sync_meta, prev_sync;
  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;
  logic          start_edge, half_done, bit_done;
  logic          clr_fe, set_fe, load;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_meta   <= 1'b1;
      serial_sync <= 1'b1;
      prev_sync   <= 1'b1;
    end else begin
      sync_meta   <= serial_in;
      serial_sync <= sync_meta;
      prev_sync   <= serial_sync;
    end
  end

  assign start_edge = prev_sync & ~serial_sync;
  assign half_done  = (clk_cnt == HALF_LAST);
  assign bit_done   = (clk_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_edge) next_state = START;
      START:    if (half_done) next_state = serial_sync ? IDLE : RECV;
      RECV:     if (bit_done && bit_cnt == LAST_IDX) next_state = STOP_CHK;
      STOP_CHK: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    shift_strobe = (state == RECV) && bit_done;
    busy         = (state != IDLE);
    clr_fe       = (state == START) && half_done && !serial_sync;
    load         = (state == STOP_CHK) && packet_data[NUM_DATA_BITS];
    set_fe       = (state == STOP_CHK) && !packet_data[NUM_DATA_BITS];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        START: begin
          clk_cnt <= half_done ? '0 : clk_cnt + 1'b1;
          bit_cnt <= '0;
        end
        RECV: begin
          if (bit_done) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // A load takes priority over a coincident data_read so the fresh byte is never lost.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (load) begin
        rx_data       <= packet_data[NUM_DATA_BITS-1:0];
        data_ready    <= 1'b1;
        overrun_error <= overrun_error | (data_ready & ~data_read);
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      if (clr_fe)      framing_error <= 1'b0;
      else if (set_fe) framing_error <= 1'b1;
    end
  end

endmodule
